project_arbiter: RTL and testbench

Shares one Q16.16→Q8.8 saturating projection datapath between NREQ requesters in the linear network.
- Round-robin arbitration, at most one grant per cycle.
- Narrows the granted word and registers it on a single valid/ready output stream, tagged with the requester ID and a saturation flag.
- Keeps a clipped-result counter for range monitoring by the layer controller.

---
 rtl/project_pkg.sv | 44 ++++
 rtl/project_arbiter_rr_arbiter.sv | 41 ++++
 rtl/project_arbiter.sv | 74 +++++++
 tb/tb_project_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// Fixed-point widths, saturation bounds and the Q16.16 -> Q8.8 projection
// shared by the projection arbiter.
package project_pkg;

  localparam int IW       = 32;
  localparam int OW       = 16;
  localparam int FRAC_IN  = IW / 2;
  localparam int FRAC_OUT = OW / 2;

  typedef logic signed [IW-1:0] q16_16_t;
  typedef logic signed [OW-1:0] q8_8_t;

  typedef struct packed {
    q8_8_t value;
    logic  clip;
  } proj_t;

  localparam q8_8_t Q88_MAX = {1'b0, {(OW-1){1'b1}}};
  localparam q8_8_t Q88_MIN = {1'b1, {(OW-1){1'b0}}};

  // Q8.8 bounds re-expressed on the Q16.16 grid (sign-extended, fraction zero).
  localparam q16_16_t Q1616_MAX =
    {{(IW-OW-FRAC_OUT){Q88_MAX[OW-1]}}, Q88_MAX, {FRAC_OUT{1'b0}}};
  localparam q16_16_t Q1616_MIN =
    {{(IW-OW-FRAC_OUT){Q88_MIN[OW-1]}}, Q88_MIN, {FRAC_OUT{1'b0}}};

  // In-range values keep the sign bit and the window of integer/fraction bits
  // that lands on Q8.8; dropped fraction bits truncate toward -inf.
  function automatic proj_t proj_sat(input q16_16_t x);
    proj_t r;
    if (x > Q1616_MAX) begin
      r.value = Q88_MAX;
      r.clip  = 1'b1;
    end else if (x < Q1616_MIN) begin
      r.value = Q88_MIN;
      r.clip  = 1'b1;
    end else begin
      r.value = {x[IW-1], x[FRAC_IN+FRAC_OUT-2 : FRAC_IN-FRAC_OUT]};
      r.clip  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/project_arbiter_rr_arbiter.sv
// Round-robin grant: scans from the pointer upward, pointer moves past the
// winner only when the grant is actually taken.
module project_arbiter_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NREQ]) begin
        found                          = 1'b1;
        grant[(int'(ptr) + k) % NREQ]  = 1'b1;
        gnt_idx                        = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // Advance past the winner on a taken grant; idle cycles leave ptr alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/project_arbiter.sv
// Shares one saturating Q16.16 -> Q8.8 projection between NREQ requesters and
// presents results on a single registered valid/ready stream.
module project_arbiter
  import project_pkg::*;
#(
  parameter int IW   = project_pkg::IW,
  parameter int OW   = project_pkg::OW,
  parameter int NREQ = 4,
  parameter int CNTW = 16,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*IW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               out_valid,
  output logic [OW-1:0]      out_data,
  output logic [IDW-1:0]     out_id,
  output logic               out_sat,
  input  logic               out_ready,
  input  logic               sat_clr,
  output logic [CNTW-1:0]    sat_cnt
);

  logic            load;
  logic            xfer;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  proj_t           proj;

  assign load = !out_valid || out_ready;

  project_arbiter_rr_arbiter #(.NREQ(NREQ), .PW(IDW)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (load && !rst),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // Accept only when the output register can take a word, never during reset.
  assign req_ready = (load && !rst) ? grant : '0;
  assign xfer      = |req_ready;
  assign proj      = proj_sat(req_data[gnt_idx*IW +: IW]);

  // Output register: reload when empty or draining, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= proj.value;
        out_id   <= gnt_idx;
        out_sat  <= proj.clip;
      end
    end
  end

  // Clipped-result counter: clear wins, otherwise count clip transfers and stick at max.
  always_ff @(posedge clk) begin
    if (rst || sat_clr) begin
      sat_cnt <= '0;
    end else if (xfer && proj.clip && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_project_arbiter.sv
module tb_project_arbiter;

  localparam int NREQ = 4;
  localparam int IW   = 32;
  localparam int OW   = 16;
  localparam int CNTW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*IW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [OW-1:0]      out_data;
  logic [1:0]         out_id;
  logic               out_sat;
  logic               out_ready;
  logic               sat_clr;
  logic [CNTW-1:0]    sat_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [1:0]    id;
    logic          sat;
  } exp_t;

  exp_t            sb[$];
  logic [CNTW-1:0] model_sat;

  project_arbiter #(.IW(IW), .OW(OW), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference projection: compare against the Q8.8 range in Q16.16, else floor-shift.
  function automatic logic [OW:0] model_proj(input logic [IW-1:0] w);
    logic signed [IW-1:0] x;
    logic signed [IW-1:0] t;
    x = w;
    if (x > 32'sh007FFF00) return {16'h7FFF, 1'b1};
    if (x < -32'sh00800000) return {16'h8000, 1'b1};
    t = x >>> 8;
    return {t[15:0], 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: scoreboard pop/push and counter model on pre-edge values, then advance.
  task automatic tick();
    exp_t        e;
    logic [OW:0] p;
    logic        clip_xfer;
    #1;
    check("ready_onehot", {31'd0, $onehot0(req_ready)}, 32'd1);
    if (rst) check("ready_in_rst", {28'd0, req_ready}, 32'd0);
    clip_xfer = 1'b0;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", {16'd0, out_data}, {16'd0, e.data});
        check("sb_id",   {30'd0, out_id},   {30'd0, e.id});
        check("sb_sat",  {31'd0, out_sat},  {31'd0, e.sat});
      end
    end
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          p = model_proj(req_data[i*IW +: IW]);
          e.data = p[OW:1];
          e.id   = 2'(i);
          e.sat  = p[0];
          sb.push_back(e);
          clip_xfer = clip_xfer | p[0];
        end
      end
    end
    if (rst) begin
      sb.delete();
      model_sat = '0;
    end else if (sat_clr) begin
      model_sat = '0;
    end else if (clip_xfer && model_sat != 16'hFFFF) begin
      model_sat = model_sat + 1'b1;
    end
    @(posedge clk);
    #1;
    check("sat_cnt_model", {16'd0, sat_cnt}, {16'd0, model_sat});
  endtask

  task automatic send_one(input logic [31:0] w, input logic [15:0] ed, input logic es);
    req_valid = 4'b0001;
    req_data[31:0] = w;
    settle();
    check("t1_ready", {28'd0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_data",  {16'd0, out_data},  {16'd0, ed});
    check("t1_sat",   {31'd0, out_sat},   {31'd0, es});
  endtask

  initial begin
    int seq_a[8];
    int seq_b[4];
    seq_a = '{0, 1, 2, 3, 0, 1, 2, 3};
    seq_b = '{0, 1, 3, 0};
    model_sat = '0;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b1;
    sat_clr = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {16'd0, out_data},  32'd0);
    check("rst_id",    {30'd0, out_id},    32'd0);
    check("rst_sat",   {31'd0, out_sat},   32'd0);
    rst = 1'b0;

    // Round robin with all requesters active, then requester 2 dropped.
    for (int i = 0; i < NREQ; i++) req_data[i*IW +: IW] = 32'(i) << 16;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("rr_ready", {28'd0, req_ready}, 32'(1 << seq_a[k]));
      tick();
      check("rr_id", {30'd0, out_id}, 32'(seq_a[k]));
    end
    req_valid = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("rr_drop_ready", {28'd0, req_ready}, 32'(1 << seq_b[k]));
      tick();
      check("rr_drop_id", {30'd0, out_id}, 32'(seq_b[k]));
    end
    req_valid = '0;
    tick();

    // In-range projections.
    send_one(32'h00018000, 16'h0180, 1'b0);
    send_one(32'h007FFF00, 16'h7FFF, 1'b0);
    send_one(32'hFF800000, 16'h8000, 1'b0);
    send_one(32'h000000FF, 16'h0000, 1'b0);
    send_one(32'hFFFFFFFF, 16'hFFFF, 1'b0);
    // Clipping.
    send_one(32'h00800000, 16'h7FFF, 1'b1);
    send_one(32'hFF7FFFFF, 16'h8000, 1'b1);
    send_one(32'h7FFFFFFF, 16'h7FFF, 1'b1);
    send_one(32'h80000000, 16'h8000, 1'b1);
    check("t2_sat_cnt", {16'd0, sat_cnt}, 32'd4);
    tick();

    // Backpressure: hold word A, then release with req1 waiting.
    req_valid = 4'b0001;
    req_data[31:0]  = 32'h00018000;
    req_data[63:32] = 32'h00020000;
    tick();
    out_ready = 1'b0;
    req_valid = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("bp_ready", {28'd0, req_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data",  {16'd0, out_data},  32'h0180);
      check("bp_id",    {30'd0, out_id},    32'd0);
      check("bp_sat",   {31'd0, out_sat},   32'd0);
    end
    out_ready = 1'b1;
    settle();
    check("bp_release_ready", {28'd0, req_ready}, 32'b0010);
    tick();
    req_valid = '0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_id",    {30'd0, out_id},    32'd1);
    check("bp_next_data",  {16'd0, out_data},  32'h0200);
    tick();

    // Counter saturation and clear priority.
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    check("clr_cnt", {16'd0, sat_cnt}, 32'd0);
    req_valid = 4'b0001;
    req_data[31:0] = 32'h7FFFFFFF;
    for (int n = 0; n < 65535; n++) tick();
    check("cnt_max", {16'd0, sat_cnt}, 32'hFFFF);
    tick();
    check("cnt_stick", {16'd0, sat_cnt}, 32'hFFFF);
    sat_clr = 1'b1;
    settle();
    check("clr_with_clip_ready", {28'd0, req_ready}, 32'd1);
    tick();
    sat_clr = 1'b0;
    check("clr_with_clip", {16'd0, sat_cnt}, 32'd0);

    // Reset while a word is held under backpressure.
    tick();
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_cnt",   {16'd0, sat_cnt},   32'd0);
    check("rst_mid_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    settle();
    check("post_rst_ready", {28'd0, req_ready}, 32'd1);
    tick();
    check("post_rst_id",    {30'd0, out_id},    32'd0);
    check("post_rst_valid", {31'd0, out_valid}, 32'd1);

    req_valid = '0;
    tick();
    tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
